// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice evaluated per clock, LSB first, with a
// registered carry feedback and a start/busy/done handshake around it.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-2:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_run;
  logic             w_last;
  logic             w_accept;
  logic             w_s_bit;
  logic             w_c_out;
  logic [WIDTH-1:0] w_res;

  // Full-adder slice on the current LSBs; w_res is the finished word on the last bit.
  assign w_s_bit  = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_c_out  = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_res    = {w_s_bit, r_acc};
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = (r_count == LAST_BIT);
  assign w_accept = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they can leave a flop.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_RUN:  w_busy_nxt = 1'b1;
      ST_DONE: w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand/carry/partial-result shifters; the counter parks at the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= {WIDTH{1'b0}};
      r_op_b  <= {WIDTH{1'b0}};
      r_acc   <= {(WIDTH-1){1'b0}};
      r_carry <= 1'b0;
      r_count <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_op_a  <= a;
      r_op_b  <= b;
      r_acc   <= {(WIDTH-1){1'b0}};
      r_carry <= cin;
      r_count <= {CNT_W{1'b0}};
    end else if (w_run) begin
      r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
      r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
      r_acc   <= w_res[WIDTH-1:1];
      r_carry <= w_c_out;
      if (!w_last) r_count <= r_count + CNT_W'(1'b1);
      else         r_count <= r_count;
    end else begin
      r_count <= r_count;
    end
  end

  // Visible result changes only on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else if (w_run && w_last) begin
      r_sum  <= w_res;
      r_cout <= w_c_out;
    end else begin
      r_sum  <= r_sum;
      r_cout <= r_cout;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8: table of operations plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = 8'h00;
  logic [W-1:0] b = 8'h00;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int ops_expected = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation; optionally poke start with junk operands at RUN cycle poke_at.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input int poke_at,
                       input logic [7:0] pa, input logic [7:0] pb, input string name);
    int busy_cnt;
    int lat;
    bit got;
    busy_cnt = 0;
    lat = -1;
    got = 1'b0;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
      if (i == poke_at) begin
        start = 1'b1; a = pa; b = pb;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    ops_expected++;
    chk({name, " done seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'd8);
    chk({name, " busy cycles"}, 32'(busy_cnt), 32'd8);
    chk({name, " sum"}, 32'(sum), 32'(es));
    chk({name, " cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({name, " done one-shot"}, 32'(done), 32'd0);
    chk({name, " sum held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    vec_t vecs[7];
    logic [8:0] ref_val;
    logic [7:0] ra, rb;
    logic       rc;
    int n_done;
    int n_idle;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'hAB, 8'hCD, 1'b0, 8'h78, 1'b1};

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
            -1, 8'h00, 8'h00, $sformatf("vec%0d", i));
    end

    do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, 8'hAA, 8'h55, "ignore_start");

    // Start held high: one result every 9 cycles, busy low one cycle in between.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    n_done = 0;
    n_idle = 0;
    for (int i = 0; i < 27; i++) begin
      if (done) begin
        n_done++;
        chk("b2b done spacing", 32'(i % 9), 32'd8);
        chk("b2b sum", 32'(sum), 32'h02);
      end
      if (!busy) n_idle++;
      if (i == 26) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    ops_expected += 3;
    chk("b2b done count", 32'(n_done), 32'd3);
    chk("b2b busy-low cycles", 32'(n_idle), 32'd3);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    chk("async rst sum", 32'(sum), 32'd0);
    chk("async rst cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("post-reset quiet", 32'(n_done), 32'd0);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, -1, 8'h00, 8'h00, "after_reset");

    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      ref_val = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      do_op(ra, rb, rc, ref_val[7:0], ref_val[8], int'($urandom_range(0, 7)) - 1,
            8'($urandom), 8'($urandom), $sformatf("rand%0d", k));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    chk("total done pulses", 32'(done_seen), 32'(ops_expected));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
